// File: rtl/afe_pkg.sv
// afe_pkg: channel state encoding and discriminator threshold constants
package afe_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HIGH} state_t;
  localparam logic [7:0] TH_BASE = 8'd16;
  localparam logic [7:0] TH_STEP = 8'd4;
  function automatic logic [7:0] threshold(input logic [3:0] tdac);
    return TH_BASE + TH_STEP * {4'd0, tdac};
  endfunction
endpackage

// File: rtl/afe_channel.sv
// afe_channel: one emulated front-end, pending-pulse FIFO plus IDLE/WAIT/HIGH pulse shaper
module afe_channel
  import afe_pkg::*;
#(
  parameter int TW = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [TW-1:0] toa,
  input  logic [TW-1:0] tot,
  input  logic          inj,
  input  logic [TW-1:0] inj_tot,
  output logic          idle,
  output logic          full,
  output logic          busy,
  output logic          pulse
);
  localparam int AW = $clog2(DEPTH);
  logic [2*TW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic [TW-1:0] cnt, tot_q;
  logic empty, pop;
  state_t state;
  assign empty = wp == rp;
  assign full = (wp - rp) == (AW+1)'(DEPTH);
  assign idle = state == IDLE;
  assign busy = ~idle | ~empty;
  assign pulse = state == HIGH;
  assign pop = idle & ~inj & ~empty;
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= {toa, tot};
  // WAIT always spends one cycle at count 0, so command latency is 2+TOA for every TOA
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      tot_q <= '0;
      state <= IDLE;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case (state)
        IDLE:
          if (inj) begin
            state <= HIGH;
            cnt <= inj_tot;
          end else if (!empty) begin
            state <= WAIT;
            {cnt, tot_q} <= mem[rp[AW-1:0]];
          end
        WAIT:
          if (cnt == '0) begin
            state <= HIGH;
            cnt <= tot_q;
          end else cnt <= cnt - 1'b1;
        HIGH:
          if (cnt[TW-1:1] == '0) begin
            state <= IDLE;
            cnt <= '0;
          end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/afe_hit_emulator.sv
// afe_hit_emulator: command decode, threshold discard, injection fan-out, drop counter and hitbus
module afe_hit_emulator
  import afe_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TW = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [$clog2(NCH)-1:0]  cmd_ch,
  input  logic [TW-1:0]           cmd_toa,
  input  logic [TW-1:0]           cmd_tot,
  input  logic [7:0]              cmd_amp,
  input  logic                    inj_strobe,
  input  logic [TW-1:0]           inj_tot,
  input  logic [4*NCH-1:0]        tdac,
  input  logic [NCH-1:0]          mask,
  input  logic [NCH-1:0]          en_inj,
  input  logic                    hb_en,
  output logic [NCH-1:0]          hit,
  output logic                    hitbus,
  output logic [NCH-1:0]          busy,
  output logic [15:0]             drop_cnt
);
  logic [NCH-1:0] full, idle, pulse, push, inj;
  logic accept, discard, inj_drop;
  logic [1:0] drops;
  logic [16:0] sum;
  assign cmd_ready = ~full[cmd_ch];
  assign accept = cmd_valid & cmd_ready;
  assign discard = mask[cmd_ch] | (cmd_amp <= threshold(tdac[4*cmd_ch +: 4]));
  assign push = NCH'(accept & ~discard) << cmd_ch;
  assign inj = {NCH{inj_strobe}} & en_inj & ~mask & idle;
  assign inj_drop = inj_strobe & |(en_inj & ~mask & ~idle);
  // a dropped injection and a discarded command can land in the same cycle
  assign drops = {1'b0, inj_drop} + {1'b0, accept & discard};
  assign sum = {1'b0, drop_cnt} + {15'd0, drops};
  assign hit = pulse & ~mask;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      drop_cnt <= '0;
      hitbus <= 1'b0;
    end else begin
      drop_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
      hitbus <= hb_en & |hit;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    afe_channel #(.TW(TW), .DEPTH(DEPTH)) u_ch (
      .clk(clk),
      .reset(reset),
      .push(push[i]),
      .toa(cmd_toa),
      .tot(cmd_tot),
      .inj(inj[i]),
      .inj_tot(inj_tot),
      .idle(idle[i]),
      .full(full[i]),
      .busy(busy[i]),
      .pulse(pulse[i])
    );
  end
endmodule

// File: tb/tb_afe_hit_emulator.sv
// tb_afe_hit_emulator: vector table with pulse scoreboard, plus hand sequences for injection, masking, FIFO full and reset
module tb_afe_hit_emulator;
  localparam int NCH = 4, TW = 8, DEPTH = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_ch = 2'd0;
  logic [TW-1:0] cmd_toa = '0, cmd_tot = '0, inj_tot = '0;
  logic [7:0] cmd_amp = 8'd0;
  logic inj_strobe = 1'b0, hb_en = 1'b0, hitbus;
  logic [4*NCH-1:0] tdac = '0;
  logic [NCH-1:0] mask = '0, en_inj = '0, hit, busy, hseen;
  logic [NCH-1:0] hprev = '0;
  logic [15:0] drop_cnt;
  int errors = 0, checks = 0, cyc = 0, mdrop = 0, acc, n;
  int start [NCH];
  bit sb_on = 1'b0;
  typedef struct {int ch; int rise; int len;} pulse_t;
  pulse_t sbq [$];
  pulse_t pm;
  typedef struct {
    logic [1:0] ch;
    logic [7:0] toa, tot, amp;
    logic [3:0] td;
    bit msk, fire;
  } vec_t;
  vec_t vt [9];

  afe_hit_emulator #(.NCH(NCH), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_toa(cmd_toa), .cmd_tot(cmd_tot), .cmd_amp(cmd_amp),
    .inj_strobe(inj_strobe), .inj_tot(inj_tot), .tdac(tdac), .mask(mask),
    .en_inj(en_inj), .hb_en(hb_en), .hit(hit), .hitbus(hitbus), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] toa, input logic [7:0] tot, input logic [7:0] amp);
    cmd_ch = ch; cmd_toa = toa; cmd_tot = tot; cmd_amp = amp; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim && busy != '0; k++) tick();
    chk("idle_timeout", busy, 0);
  endtask

  // scoreboard: every completed pulse is matched against the oldest expected one
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (hit[c] && !hprev[c]) start[c] = cyc;
      if (sb_on && !hit[c] && hprev[c]) begin
        chk("pulse_expected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          pm = sbq.pop_front();
          chk("pulse_ch", c, pm.ch);
          chk("pulse_rise", start[c], pm.rise);
          chk("pulse_len", cyc - start[c], pm.len);
        end
      end
    end
    hprev = hit;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'd1, 8'd3, 8'd5, 8'd200, 4'd0, 1'b0, 1'b1};
    vt[1] = '{2'd0, 8'd0, 8'd0, 8'd100, 4'd0, 1'b0, 1'b1};
    vt[2] = '{2'd0, 8'd5, 8'd5, 8'd20, 4'd2, 1'b0, 1'b0};
    vt[3] = '{2'd3, 8'd1, 8'd1, 8'd76, 4'd15, 1'b0, 1'b0};
    vt[4] = '{2'd3, 8'd1, 8'd2, 8'd77, 4'd15, 1'b0, 1'b1};
    vt[5] = '{2'd2, 8'd0, 8'd1, 8'd17, 4'd0, 1'b0, 1'b1};
    vt[6] = '{2'd2, 8'd0, 8'd1, 8'd16, 4'd0, 1'b0, 1'b0};
    vt[7] = '{2'd1, 8'd2, 8'd2, 8'd200, 4'd0, 1'b1, 1'b0};
    vt[8] = '{2'd0, 8'd7, 8'd3, 8'd255, 4'd15, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hitbus", hitbus, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    tick();

    sb_on = 1'b1;
    foreach (vt[i]) begin
      tdac = '0;
      tdac[4*vt[i].ch +: 4] = vt[i].td;
      mask = '0;
      mask[vt[i].ch] = vt[i].msk;
      chk("tbl_ready", cmd_ready, 1);
      send(vt[i].ch, vt[i].toa, vt[i].tot, vt[i].amp);
      if (vt[i].fire)
        sbq.push_back('{int'(vt[i].ch), cyc + 2 + int'(vt[i].toa), vt[i].tot == 8'd0 ? 1 : int'(vt[i].tot)});
      else mdrop++;
      mask = '0;
      wait_idle(200);
      repeat (2) tick();
      chk("tbl_drop", drop_cnt, mdrop);
      chk("tbl_sb_empty", sbq.size(), 0);
    end
    sb_on = 1'b0;

    // injection into an idle channel while another enabled channel is waiting
    tdac = '0;
    send(2'd1, 8'd20, 8'd3, 8'd200);
    repeat (3) tick();
    en_inj = 4'b0011; inj_tot = 8'd2; inj_strobe = 1'b1;
    tick();
    inj_strobe = 1'b0;
    mdrop++;
    chk("inj_hit0_first", hit[0], 1);
    chk("inj_hit1", hit[1], 0);
    chk("inj_busy1", busy[1], 1);
    chk("inj_drop", drop_cnt, mdrop);
    tick();
    chk("inj_hit0_second", hit[0], 1);
    tick();
    chk("inj_hit0_end", hit[0], 0);
    wait_idle(100);

    // injection beats a same-cycle pop; the queued command fires afterwards
    en_inj = 4'b0001;
    send(2'd0, 8'd0, 8'd0, 8'd200);
    inj_strobe = 1'b1;
    tick();
    inj_strobe = 1'b0;
    chk("prio_hit", hit[0], 1);
    repeat (2) tick();
    chk("prio_gap", hit[0], 0);
    chk("prio_busy", busy[0], 1);
    repeat (2) tick();
    chk("prio_queued_pulse", hit[0], 1);
    tick();
    chk("prio_queued_end", hit[0], 0);
    chk("prio_drop", drop_cnt, mdrop);
    en_inj = '0;

    // mask raised mid-pulse
    hb_en = 1'b1;
    send(2'd0, 8'd0, 8'd6, 8'd200);
    repeat (3) tick();
    chk("mask_pre_hit", hit[0], 1);
    chk("mask_pre_hitbus", hitbus, 1);
    mask[0] = 1'b1;
    #1;
    chk("mask_hit_now", hit[0], 0);
    chk("mask_busy", busy[0], 1);
    tick();
    chk("mask_hitbus", hitbus, 0);
    repeat (3) tick();
    chk("mask_busy_hold", busy[0], 1);
    tick();
    chk("mask_busy_end", busy[0], 0);
    mask = '0; hb_en = 1'b0;

    // fill ch2 behind a long TOA, then wait for space
    cmd_ch = 2'd2; cmd_toa = 8'd50; cmd_tot = 8'd1; cmd_amp = 8'd200; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("fill_ready", cmd_ready, 1);
      tick();
    end
    acc = cyc - 4;
    chk("full_ready", cmd_ready, 0);
    cmd_ch = 2'd3;
    #1;
    chk("full_other_ch_ready", cmd_ready, 1);
    cmd_ch = 2'd2;
    #1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
    chk("sixth_accept_edge", cyc, acc + 55);
    repeat (5) tick();
    chk("pre_rst_busy", busy[2], 1);
    chk("pre_rst_drop", drop_cnt, mdrop);
    #3 reset = 1'b1;
    #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_hit", hit, 0);
    chk("rst_wait_drop", drop_cnt, 0);
    chk("rst_wait_ready", cmd_ready, 1);
    tick();
    reset = 1'b0;
    hseen = '0;
    repeat (20) begin
      tick();
      hseen |= hit;
    end
    chk("post_rst_hit", hseen, 0);
    chk("post_rst_busy", busy, 0);

    // reset in the middle of a pulse
    send(2'd3, 8'd0, 8'd10, 8'd200);
    repeat (4) tick();
    chk("midpulse_hit", hit[3], 1);
    #2 reset = 1'b1;
    #1;
    chk("midpulse_rst_hit", hit, 0);
    tick();
    reset = 1'b0;
    hseen = '0;
    repeat (20) begin
      tick();
      hseen |= hit;
    end
    chk("midpulse_post_hit", hseen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
